triangle_fill: RTL

//  Filled-triangle rasteriser; draw stage beside Line and Flip, downstream of ComCtrl (oGo & oTriangle).

---
 rtl/triangle_fill_if.sv | 32 +++
 rtl/triangle_fill.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_fill_if.sv
// triangle_fill_if: command and write-port bundle between ComCtrl, the triangle
// rasteriser and FrameCtrl port 1.
//
// Handshake: iGo is a one-cycle request. It is accepted only while the
// rasteriser is idle, which is shown by oDone=1. oWrEn is a valid-only strobe
// and has no ready. The consumer must take one oAdr write on every cycle that
// oWrEn=1.
// dbgState mirrors the rasteriser FSM: 0 IDLE, 1 SETUP, 2 INIT, 3 SCAN.
interface triangle_fill_if;
    logic        iGo;
    logic [7:0]  iX0;
    logic [7:0]  iY0;
    logic [7:0]  iX1;
    logic [7:0]  iY1;
    logic [7:0]  iX2;
    logic [7:0]  iY2;
    logic        oDone;
    logic [15:0] oAdr;
    logic        oWrEn;
    logic [15:0] oPixCnt;
    logic [1:0]  dbgState;

    modport master (
        output iGo, iX0, iY0, iX1, iY1, iX2, iY2,
        input  oDone, oAdr, oWrEn, oPixCnt, dbgState
    );

    modport slave (
        input  iGo, iX0, iY0, iX1, iY1, iX2, iY2,
        output oDone, oAdr, oWrEn, oPixCnt, dbgState
    );
endinterface

// File: rtl/triangle_fill.sv
// triangle_fill: filled-triangle rasteriser.
// The module walks the clipped vertex bounding box one pixel per clock and
// tests three edge functions at each pixel. For every covered pixel it emits
// the frame address y*WIDTH+x.
// Optional feature: define TRIANGLE_FILL_STATS_EN to build the oPixCnt
// written-pixel counter. Without it, oPixCnt is tied to 0.
// Vertex coordinates are 8 bits wide, so WIDTH and HEIGHT must each be <= 256.
module triangle_fill #(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 160
) (
    input  logic            iClk,
    input  logic            iRst_,
    triangle_fill_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        INIT  = 2'd2,
        SCAN  = 2'd3
    } stateT;

    localparam logic [7:0]  XLIM    = 8'(WIDTH - 1);
    localparam logic [7:0]  YLIM    = 8'(HEIGHT - 1);
    localparam logic [15:0] STRIDE  = 16'(WIDTH);

    stateT state;
    stateT stateNext;

    // Latched vertices
    logic [7:0] vx0, vy0, vx1, vy1, vx2, vy2;

    // Clipped bounding box and scan position
    logic [7:0] xMin, xMax, yMin, yMax;
    logic [7:0] curX, curY;

    // Edge deltas. After INIT they hold the winding-normalised step values.
    logic signed [8:0] dX01, dY01, dX12, dY12, dX20, dY20;

    // Edge function values at the current pixel and at the current row start
    logic signed [19:0] e01, e12, e20;
    logic signed [19:0] rowE01, rowE12, rowE20;

    // Output registers
    logic        doneReg;
    logic        wrEnReg;
    logic [15:0] adrReg;

    // Combinational helpers
    logic [7:0]         xMinRaw, xMaxRaw, yMinRaw, yMaxRaw, xMaxClip, yMaxClip;
    logic               degenerate;
    logic signed [19:0] init01, init12, init20, area;
    logic               areaNeg;
    logic               covered;
    logic               lastPix;
    logic               rowEnd;
    logic [15:0]        pixAdr;
    logic signed [19:0] nextRow01, nextRow12, nextRow20;

    function automatic logic [7:0] min3(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        logic [7:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [7:0] max3(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        logic [7:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic signed [19:0] ext9(input logic signed [8:0] v);
        return {{11{v[8]}}, v};
    endfunction

    // (px-ax)*dy - (py-ay)*dx. With 8-bit coordinates the magnitude stays below 2^18.
    function automatic logic signed [19:0] edgeFn(
        input logic [7:0] px, input logic [7:0] py,
        input logic [7:0] ax, input logic [7:0] ay,
        input logic signed [8:0] dx, input logic signed [8:0] dy);
        logic signed [19:0] relX;
        logic signed [19:0] relY;
        relX = $signed({12'd0, px}) - $signed({12'd0, ax});
        relY = $signed({12'd0, py}) - $signed({12'd0, ay});
        return relX * ext9(dy) - relY * ext9(dx);
    endfunction

    // Bounding box, clipping, edge setup and coverage terms
    always_comb begin
        xMinRaw    = min3(vx0, vx1, vx2);
        xMaxRaw    = max3(vx0, vx1, vx2);
        yMinRaw    = min3(vy0, vy1, vy2);
        yMaxRaw    = max3(vy0, vy1, vy2);
        xMaxClip   = (xMaxRaw > XLIM) ? XLIM : xMaxRaw;
        yMaxClip   = (yMaxRaw > YLIM) ? YLIM : yMaxRaw;
        degenerate = (xMinRaw > xMaxClip) || (yMinRaw > yMaxClip);

        init01  = edgeFn(xMin, yMin, vx0, vy0, dX01, dY01);
        init12  = edgeFn(xMin, yMin, vx1, vy1, dX12, dY12);
        init20  = edgeFn(xMin, yMin, vx2, vy2, dX20, dY20);
        area    = edgeFn(vx2, vy2, vx0, vy0, dX01, dY01);
        areaNeg = area[19];

        covered   = !e01[19] && !e12[19] && !e20[19];
        rowEnd    = (curX == xMax);
        lastPix   = rowEnd && (curY == yMax);
        pixAdr    = {8'd0, curY} * STRIDE + {8'd0, curX};
        nextRow01 = rowE01 - ext9(dX01);
        nextRow12 = rowE12 - ext9(dX12);
        nextRow20 = rowE20 - ext9(dX20);
    end

    // FSM state register
    always_ff @(posedge iClk or negedge iRst_) begin
        if (!iRst_) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // FSM next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (bus.iGo) stateNext = SETUP;
            SETUP:   stateNext = degenerate ? IDLE : INIT;
            INIT:    stateNext = (area == 20'sd0) ? IDLE : SCAN;
            SCAN:    if (lastPix) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Datapath: vertex latch, setup, winding normalisation, scan stepping and output registers
    always_ff @(posedge iClk or negedge iRst_) begin
        if (!iRst_) begin
            vx0 <= '0; vy0 <= '0; vx1 <= '0; vy1 <= '0; vx2 <= '0; vy2 <= '0;
            xMin <= '0; xMax <= '0; yMin <= '0; yMax <= '0;
            curX <= '0; curY <= '0;
            dX01 <= '0; dY01 <= '0; dX12 <= '0; dY12 <= '0; dX20 <= '0; dY20 <= '0;
            e01 <= '0; e12 <= '0; e20 <= '0;
            rowE01 <= '0; rowE12 <= '0; rowE20 <= '0;
            doneReg <= 1'b1;
            wrEnReg <= 1'b0;
            adrReg  <= '0;
        end else begin
            wrEnReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.iGo) begin
                        vx0 <= bus.iX0; vy0 <= bus.iY0;
                        vx1 <= bus.iX1; vy1 <= bus.iY1;
                        vx2 <= bus.iX2; vy2 <= bus.iY2;
                        doneReg <= 1'b0;
                    end else begin
                        // The last write strobe has gone out by now, so report finished.
                        doneReg <= 1'b1;
                    end
                end
                SETUP: begin
                    xMin <= xMinRaw;
                    xMax <= xMaxClip;
                    yMin <= yMinRaw;
                    yMax <= yMaxClip;
                    dX01 <= $signed({1'b0, vx1}) - $signed({1'b0, vx0});
                    dY01 <= $signed({1'b0, vy1}) - $signed({1'b0, vy0});
                    dX12 <= $signed({1'b0, vx2}) - $signed({1'b0, vx1});
                    dY12 <= $signed({1'b0, vy2}) - $signed({1'b0, vy1});
                    dX20 <= $signed({1'b0, vx0}) - $signed({1'b0, vx2});
                    dY20 <= $signed({1'b0, vy0}) - $signed({1'b0, vy2});
                end
                INIT: begin
                    // Flip clockwise triangles so that "inside" always means E >= 0.
                    e01    <= areaNeg ? -init01 : init01;
                    e12    <= areaNeg ? -init12 : init12;
                    e20    <= areaNeg ? -init20 : init20;
                    rowE01 <= areaNeg ? -init01 : init01;
                    rowE12 <= areaNeg ? -init12 : init12;
                    rowE20 <= areaNeg ? -init20 : init20;
                    if (areaNeg) begin
                        dX01 <= -dX01; dY01 <= -dY01;
                        dX12 <= -dX12; dY12 <= -dY12;
                        dX20 <= -dX20; dY20 <= -dY20;
                    end
                    curX <= xMin;
                    curY <= yMin;
                end
                SCAN: begin
                    wrEnReg <= covered;
                    if (covered) begin
                        adrReg <= pixAdr;
                    end
                    if (!lastPix) begin
                        if (rowEnd) begin
                            curX   <= xMin;
                            curY   <= curY + 8'd1;
                            rowE01 <= nextRow01;
                            rowE12 <= nextRow12;
                            rowE20 <= nextRow20;
                            e01    <= nextRow01;
                            e12    <= nextRow12;
                            e20    <= nextRow20;
                        end else begin
                            curX <= curX + 8'd1;
                            e01  <= e01 + ext9(dY01);
                            e12  <= e12 + ext9(dY12);
                            e20  <= e20 + ext9(dY20);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TRIANGLE_FILL_STATS_EN
    logic [15:0] pixCnt;

    // Written-pixel counter: cleared on each accepted start, bumped per write strobe
    always_ff @(posedge iClk or negedge iRst_) begin
        if (!iRst_) begin
            pixCnt <= '0;
        end else if (state == IDLE && bus.iGo) begin
            pixCnt <= '0;
        end else if (wrEnReg) begin
            pixCnt <= pixCnt + 16'd1;
        end
    end

    assign bus.oPixCnt = pixCnt;
`else
    assign bus.oPixCnt = '0;
`endif

    assign bus.oDone    = doneReg;
    assign bus.oWrEn    = wrEnReg;
    assign bus.oAdr     = adrReg;
    assign bus.dbgState = state;

endmodule
